// File: rtl/sym_feeder.sv
// Symbol feeder for the 0-6-4-2 sequence detector: valid/ready FIFO, registered output, saturating delivery count.
// Optional macro SYM_FEEDER_BYPASS_EN: an empty FIFO forwards an accepted symbol straight to out_sym on the same edge.
module sym_feeder #(
    parameter int         DEPTH    = 8,
    parameter logic [2:0] IDLE_SYM = 3'd7,
    parameter int         CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [2:0]               in_data,
    output logic                     in_ready,
    input  logic                     out_en,
    input  logic                     flush,
    output logic [2:0]               out_sym,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         sent_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [2:0]    out_sym_r;
    logic          out_valid_r;
    logic [CNT_W-1:0] sent_cnt_r;

    logic full_s;
    logic empty_s;
    logic in_ready_s;
    logic accept_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;
    logic cnt_max_s;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    // Handshake and FIFO control decode
    always_comb begin
        full_s     = (level_r == LW'(DEPTH));
        empty_s    = (level_r == {LW{1'b0}});
        in_ready_s = !full_s && !flush;
        accept_s   = in_valid && in_ready_s;
`ifdef SYM_FEEDER_BYPASS_EN
        bypass_s   = accept_s && out_en && empty_s;
`else
        bypass_s   = 1'b0;
`endif
        push_s     = accept_s && !bypass_s;
        pop_s      = out_en && !empty_s && !flush;
        cnt_max_s  = &sent_cnt_r;
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers, occupancy, output register and delivery counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            out_sym_r   <= IDLE_SYM;
            out_valid_r <= 1'b0;
            sent_cnt_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            // sent_cnt deliberately survives a flush
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            level_r     <= {LW{1'b0}};
            out_sym_r   <= IDLE_SYM;
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LW'(1);
            end else if (pop_s && !push_s) begin
                level_r <= level_r - LW'(1);
            end else begin
                level_r <= level_r;
            end
            if (pop_s) begin
                out_sym_r   <= mem_r[rd_ptr_r];
                out_valid_r <= 1'b1;
            end else if (bypass_s) begin
                out_sym_r   <= in_data;
                out_valid_r <= 1'b1;
            end else if (out_en) begin
                // starved: idle symbol breaks any partial match downstream
                out_sym_r   <= IDLE_SYM;
                out_valid_r <= 1'b0;
            end else begin
                out_sym_r   <= out_sym_r;
                out_valid_r <= out_valid_r;
            end
            if ((pop_s || bypass_s) && !cnt_max_s) begin
                sent_cnt_r <= sent_cnt_r + CNT_W'(1);
            end else begin
                sent_cnt_r <= sent_cnt_r;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_sym   = out_sym_r;
    assign out_valid = out_valid_r;
    assign level     = level_r;
    assign sent_cnt  = sent_cnt_r;

endmodule

// File: tb/tb_sym_feeder.sv
// Scoreboard bench for sym_feeder: queue-based reference model predicts each edge, monitor compares.
module tb_sym_feeder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_data = 3'd0;
    logic        out_en = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready, in_ready2;
    logic [2:0]  out_sym, out_sym2;
    logic        out_valid, out_valid2;
    logic [3:0]  level, level2;
    logic [15:0] sent_cnt;
    logic [1:0]  sent_cnt2;

    sym_feeder #(.DEPTH(DEPTH), .IDLE_SYM(3'd7), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_en(out_en), .flush(flush), .out_sym(out_sym), .out_valid(out_valid),
        .level(level), .sent_cnt(sent_cnt));

    sym_feeder #(.DEPTH(DEPTH), .IDLE_SYM(3'd7), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
        .out_en(out_en), .flush(flush), .out_sym(out_sym2), .out_valid(out_valid2),
        .level(level2), .sent_cnt(sent_cnt2));

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [2:0] sym;
        int         lvl;
        int         cnt16;
        int         cnt2;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] mq[$];     // reference FIFO contents
    logic [2:0] src[$];    // producer backlog
    int         delivered = 0;
    logic       last_valid = 1'b0;
    logic [2:0] last_sym = 3'd7;
    bit         armed = 1'b0;
    int         errors = 0;
    int         checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, predict the coming edge, queue the expectation.
    task automatic step(input bit offer, input bit en, input bit fl, input bit do_rst);
        exp_t       e;
        logic       v;
        logic [2:0] d;
        bit         rdy, acc, byp, dv;
        @(negedge clk);
        v = offer && (src.size() != 0);
        d = v ? src[0] : 3'($urandom_range(0, 7));
        in_valid = v; in_data = d; out_en = en; flush = fl;
        if (do_rst) begin
            rst = 1'b1;
            #1;
            chk("rst_out_sym", out_sym, 3'd7);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_level", level, 4'd0);
            chk("rst_sent_cnt", sent_cnt, 16'd0);
            chk("rst_in_ready", in_ready, !fl);
            rst = 1'b0;
            mq.delete();
            delivered = 0; last_valid = 1'b0; last_sym = 3'd7;
        end
        #1;
        rdy = !fl && (mq.size() != DEPTH);
        chk("in_ready", in_ready, rdy);
        chk("in_ready_w2", in_ready2, rdy);
        acc = v && rdy;
        byp = 1'b0; dv = 1'b0;
        if (fl) begin
            mq.delete();
            last_valid = 1'b0; last_sym = 3'd7;
        end else if (en) begin
            if (mq.size() != 0) begin
                last_sym = mq.pop_front(); dv = 1'b1;
            end else begin
`ifdef SYM_FEEDER_BYPASS_EN
                if (acc) begin
                    last_sym = d; dv = 1'b1; byp = 1'b1;
                end
`endif
            end
            if (!dv) last_sym = 3'd7;
            last_valid = dv;
        end
        if (acc && !byp) mq.push_back(d);
        if (acc) void'(src.pop_front());
        if (dv) delivered++;
        e.valid = last_valid;
        e.sym   = last_sym;
        e.lvl   = mq.size();
        e.cnt16 = (delivered > 65535) ? 65535 : delivered;
        e.cnt2  = (delivered > 3) ? 3 : delivered;
        exp_q.push_back(e);
        armed = 1'b1;
    endtask

    // Monitor: after every active edge, compare the DUT against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (armed) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_valid", out_valid, e.valid);
                chk("out_sym", out_sym, e.sym);
                chk("level", level, e.lvl);
                chk("sent_cnt", sent_cnt, e.cnt16);
                chk("sent_cnt_w2", sent_cnt2, e.cnt2);
                chk("out_sym_w2", out_sym2, e.sym);
                chk("level_w2", level2, e.lvl);
                chk("out_valid_w2", out_valid2, e.valid);
            end
        end
    end

    initial begin
        #3 rst = 1'b0;
        // asynchronous reset with no clock edge involved
        step(1'b0, 1'b0, 1'b0, 1'b1);
        // 0,6,4,2 stream with consumer enabled, then starve
        src = '{3'd0, 3'd6, 3'd4, 3'd2};
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        // fill past DEPTH with consumer stalled, then drain
        for (int i = 0; i < 9; i++) src.push_back(3'(i));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        // steady state at level 3 with simultaneous push and pop
        for (int i = 0; i < 8; i++) src.push_back(3'($urandom_range(0, 7)));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        // flush at level 5 while a symbol is offered
        for (int i = 0; i < 6; i++) src.push_back(3'($urandom_range(0, 7)));
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        src.delete();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            if (src.size() < 4) src.push_back(3'($urandom_range(0, 7)));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 149) == 0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
